instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch stage of the RISC processor. It owns the program counter, drives the instruction memory read port and delivers fetched words with their PC to the decode stage over a valid/ready handshake. A 2-entry buffer absorbs the one-cycle memory read latency so that decode back-pressure never drops or duplicates an instruction. Redirect (branch/jump) and halt requests come from downstream.

## Interface
- ADDR_WIDTH, 32: PC and instruction-memory address width.
- DATA_WIDTH, 32: instruction width.
- RESET_PC, 0: first fetch address after reset.
- PC_STEP, 1: PC increment per instruction; memory is word-addressed.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- im_addr  out  ADDR_WIDTH  IM read address.
- im_oen  out  1  IM output enable, active-low; 0 means a read is issued this cycle.
- im_wen  out  1  IM write enable, active-low; tied to 1.
- im_dataout  in  DATA_WIDTH  IM read data, valid in the cycle after the issue.
- if_valid  out  1  buffer head holds a valid instruction.
- if_ir  out  DATA_WIDTH  instruction at buffer head.
- if_pc  out  ADDR_WIDTH  address of if_ir.
- id_ready  in  1  decode accepts the head this cycle.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- halt  in  1  stop issuing new fetches.

## Operation
- State machine:
  - IDLE is the reset state; no issue.
  - IDLE → FETCH unconditionally on the next edge.
  - FETCH → HALTED when halt=1.
  - HALTED → FETCH only when redirect=1.
  - redirect=1 in any state goes to FETCH; redirect beats halt.
- Registers:
  - pc is the next fetch address.
  - inflight plus inflight_pc track the single outstanding read.
  - squash marks the outstanding read as discarded.
  - The buffer is a 2-entry FIFO of {ir, pc} with count 0..2.
- pop = if_valid & id_ready & ~redirect.
- issue = (state==FETCH) & ~halt & ~redirect & (count + inflight − pop < 2). This is combinational.
- im_oen = ~issue. im_addr = pc when issuing, otherwise it holds its last issued value.
- On issue, at the edge:
  - pc ← pc + PC_STEP, wrapping modulo 2^ADDR_WIDTH.
  - inflight ← 1 and inflight_pc ← pc.
  - Otherwise inflight ← 0.
- Return: in a cycle with inflight=1, im_dataout is pushed with inflight_pc at the edge unless squash=1. Squashed data is dropped.
- Simultaneous pop and push keep count unchanged. Push order is preserved. The occupancy rule guarantees a push never finds the buffer full.
- Redirect, at the edge:
  - Buffer cleared (count ← 0).
  - pc ← redirect_pc.
  - squash ← inflight.
  - Any pop is ignored.
- HALTED:
  - No new issues.
  - An in-flight return is still pushed.
  - Buffered entries still drain to decode.
- halt has no effect in IDLE.
- Reset mid-operation: everything returns to reset values at the edge. In-flight data is dropped; squash and inflight are cleared.

## Timing
- Reset values:
  - im_oen=1, im_wen=1, im_addr=RESET_PC.
  - if_valid=0, if_ir=0, if_pc=0.
  - state=IDLE, pc=RESET_PC, count=0.
  - inflight=0, squash=0.
- If_ir, if_pc and if_valid are registered (buffer head). im_addr and im_oen are combinational from registered state and inputs.
- Startup, with E1 = first edge with rst_n=1:
  - E1: IDLE → FETCH.
  - Cycle after E1: im_oen=0, im_addr=RESET_PC.
  - After E2: data on im_dataout.
  - After E3: if_valid=1, if_pc=RESET_PC.
- Fetch latency is 2 cycles from issue to if_valid. With id_ready held at 1, throughput is 1 instruction/cycle.
- Redirect penalty: after the redirect edge Er, im_addr=redirect_pc in the next cycle. if_valid=1 with if_pc=redirect_pc after Er+2. if_valid=0 for the 2 cycles in between.
- id_ready low for N cycles: at most 2 buffered plus 0 outstanding, so issue stops. Issue resumes in the same cycle that pop=1.

## Test plan
- Reset then run, IM[k]=0x1000_0000+k, id_ready=1 → check three things:
  - Cycle after E1: im_addr=0, im_oen=0.
  - if_valid first rises after E3 with if_pc=0, if_ir=0x1000_0000.
  - if_pc then increments by 1 every cycle with no gaps.
- Back-pressure: id_ready=0 for 5 cycles mid-stream at if_pc=4 → check:
  - if_pc holds 4.
  - im_oen=1 once count=2.
  - On release, decode receives 4,5,6,… with no skip or repeat.
- Redirect with redirect_pc=0x40 while the buffer is full and a read is in flight → check:
  - Buffer flushed and old in-flight data dropped.
  - im_addr=0x40 the next cycle.
  - if_pc=0x40 after Er+2, then 0x41.
- halt at if_pc=8 → check:
  - No further issues (im_oen=1).
  - Buffered/in-flight entries drain, then if_valid=0.
  - A later redirect to 0x10 resumes fetch, with if_pc=0x10 two cycles later.
- Simultaneous halt and redirect (redirect_pc=0x20) → check:
  - State stays FETCH.
  - im_addr=0x20 is issued the next cycle.
- Reset asserted for one cycle mid-stream → check:
  - All outputs return to reset values at that edge.
  - The refetch starts at RESET_PC with the same startup timing.
  - No stale instruction appears.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues instruction-memory reads and hands {ir, pc}
// to decode through a 2-entry buffer that covers the one-cycle read latency.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_WIDTH-1:0] o_im_addr,
    output logic                  o_im_oen,
    output logic                  o_im_wen,
    input  logic [DATA_WIDTH-1:0] i_im_dataout,
    output logic                  o_if_valid,
    output logic [DATA_WIDTH-1:0] o_if_ir,
    output logic [ADDR_WIDTH-1:0] o_if_pc,
    input  logic                  i_id_ready,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    input  logic                  i_halt
);
    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, r_inflight_pc, r_last_addr;
    logic                  r_inflight, r_squash;
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_ir  [2];
    logic [ADDR_WIDTH-1:0] r_bpc [2];
    logic                  w_pop, w_push, w_issue, w_widx;
    logic [2:0]            w_occ;

    always_comb begin
        w_state_nxt = r_state;
        if (i_redirect)
            w_state_nxt = FETCH;
        else if (r_state == IDLE)
            w_state_nxt = FETCH;
        else if (r_state == FETCH && i_halt)
            w_state_nxt = HALTED;
    end

    // Occupancy counts the outstanding read so a returning word always finds a slot.
    assign w_occ     = {1'b0, r_count} + {2'b0, r_inflight};
    assign w_pop     = o_if_valid & i_id_ready & ~i_redirect;
    assign w_issue   = (r_state == FETCH) & ~i_halt & ~i_redirect & (w_occ < 3'd2 + {2'b0, w_pop});
    assign w_push    = r_inflight & ~r_squash & ~i_redirect;
    assign w_widx    = r_count[1] | (r_count[0] & ~w_pop);
    assign o_if_valid = (r_count != 2'd0);
    assign o_if_ir   = r_ir[0];
    assign o_if_pc   = r_bpc[0];
    assign o_im_oen  = ~w_issue;
    assign o_im_wen  = 1'b1;
    assign o_im_addr = w_issue ? r_pc : r_last_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_last_addr   <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_squash      <= 1'b0;
            r_count       <= 2'd0;
            r_ir[0]       <= '0;
            r_ir[1]       <= '0;
            r_bpc[0]      <= '0;
            r_bpc[1]      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            r_squash   <= i_redirect & r_inflight;
            if (w_issue) begin
                r_pc          <= r_pc + ADDR_WIDTH'(PC_STEP);
                r_inflight_pc <= r_pc;
                r_last_addr   <= r_pc;
            end
            if (i_redirect) begin
                r_pc    <= i_redirect_pc;
                r_count <= 2'd0;
            end else begin
                if (w_pop) begin
                    r_ir[0]  <= r_ir[1];
                    r_bpc[0] <= r_bpc[1];
                end
                // Written after the shift so a push into slot 0 wins over it.
                if (w_push) begin
                    r_ir[w_widx]  <= i_im_dataout;
                    r_bpc[w_widx] <= r_inflight_pc;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed timing checks plus randomized traffic; delivered
// instructions are scoreboarded against the expected sequential/redirected PC stream.
module tb_instr_fetch_unit;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] im_addr;
    logic          im_oen, im_wen;
    logic [DW-1:0] im_dataout;
    logic          if_valid;
    logic [DW-1:0] if_ir;
    logic [AW-1:0] if_pc;
    logic          id_ready = 1'b1;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0), .PC_STEP(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_im_addr(im_addr), .o_im_oen(im_oen), .o_im_wen(im_wen),
        .i_im_dataout(im_dataout), .o_if_valid(if_valid), .o_if_ir(if_ir), .o_if_pc(if_pc),
        .i_id_ready(id_ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_halt(halt)
    );

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // Instruction memory: one-cycle read latency, garbage when no read was issued.
    always @(posedge clk) im_dataout <= !im_oen ? memf(im_addr) : 32'hDEAD_BEEF;

    typedef struct packed {logic [DW-1:0] ir; logic [AW-1:0] pc;} ent_t;
    ent_t          q[$];
    ent_t          e;
    int            n_cmp = 0, n_fail = 0, n_deliv = 0;
    logic [AW-1:0] exp_next;
    bit            halted = 0, idle = 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic refill();
        while (q.size() < 8) begin
            q.push_back({memf(exp_next), exp_next});
            exp_next = exp_next + 1;
        end
    endtask

    task automatic restart(input logic [AW-1:0] pc);
        q.delete();
        exp_next = pc;
        refill();
    endtask

    // Advance one clock; track the abstract halted/idle condition from the inputs seen at the edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            halted = 0;
            idle   = 1;
        end else begin
            if (redirect) halted = 0;
            else if (halt && !idle) halted = 1;
            idle = 0;
        end
        #1;
        refill();
    endtask

    task automatic set_redirect(input logic [AW-1:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        restart(pc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_oen"}, im_oen, 1);
        chk({tag, "_wen"}, im_wen, 1);
        chk({tag, "_addr"}, im_addr, 0);
        chk({tag, "_valid"}, if_valid, 0);
        chk({tag, "_ir"}, if_ir, 0);
        chk({tag, "_pc"}, if_pc, 0);
    endtask

    task automatic startup(input string tag);
        step();
        chk({tag, "_e1_oen"}, im_oen, 0);
        chk({tag, "_e1_addr"}, im_addr, 0);
        chk({tag, "_e1_valid"}, if_valid, 0);
        step();
        chk({tag, "_e2_valid"}, if_valid, 0);
        step();
        chk({tag, "_e3_valid"}, if_valid, 1);
        chk({tag, "_e3_pc"}, if_pc, 0);
        chk({tag, "_e3_ir"}, if_ir, 32'h1000_0000);
    endtask

    task automatic wait_pc(input logic [AW-1:0] target);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (if_valid && if_pc == target) found = 1;
            else step();
        end
        chk("wait_pc_reached", found, 1);
    endtask

    task automatic redir_check(input logic [AW-1:0] pc, input bit with_halt);
        halt = with_halt;
        set_redirect(pc);
        #1;
        chk("redir_cycle_oen", im_oen, 1);
        step();
        redirect = 1'b0;
        halt     = 1'b0;
        #1;
        chk("redir_next_oen", im_oen, 0);
        chk("redir_next_addr", im_addr, pc);
        chk("redir_gap1_valid", if_valid, 0);
        step();
        chk("redir_gap2_valid", if_valid, 0);
        step();
        chk("redir_valid", if_valid, 1);
        chk("redir_pc", if_pc, pc);
        chk("redir_ir", if_ir, memf(pc));
        step();
        chk("redir_pc_plus1", if_pc, pc + 1);
    endtask

    // Monitor: every accepted handshake must match the head of the expected stream.
    always @(negedge clk) begin
        if (rst_n && if_valid === 1'b1 && id_ready && !redirect) begin
            n_deliv++;
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = q.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_ir", if_ir, e.ir);
            end
        end
    end

    initial begin
        restart('0);
        step();
        step();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        startup("boot");
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("stream_valid", if_valid, 1);
            chk("stream_pc", if_pc, i);
        end
        // Back-pressure at pc 4 for five cycles.
        wait_pc(4);
        id_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_pc", if_pc, 4);
            chk("bp_valid", if_valid, 1);
            chk("bp_oen", im_oen, 1);
            step();
        end
        id_ready = 1'b1;
        #1;
        chk("bp_release_oen", im_oen, 0);
        chk("bp_release_addr", im_addr, 6);
        // Halt at pc 8: drains the buffered and in-flight words, then goes quiet.
        wait_pc(8);
        halt = 1'b1;
        #1;
        chk("halt_oen", im_oen, 1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("halted_oen", im_oen, 1);
            chk("halted_valid", if_valid, k == 0);
            if (k == 0) chk("halted_drain_pc", if_pc, 9);
        end
        halt = 1'b0;
        redir_check(32'h10, 0);
        repeat (3) step();
        redir_check(32'h40, 0);
        // Redirect while the buffer is full.
        id_ready = 1'b0;
        step();
        step();
        chk("full_count_oen", im_oen, 1);
        id_ready = 1'b1;
        redir_check(32'h30, 0);
        redir_check(32'h20, 1);
        // One-cycle reset mid-stream.
        repeat (3) step();
        rst_n = 1'b0;
        restart('0);
        step();
        rst_n = 1'b1;
        #1;
        chk_reset_vals("midrst");
        startup("reboot");
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            id_ready = ($urandom % 10) < 7;
            halt     = ($urandom % 50) == 0;
            redirect = 1'b0;
            if (($urandom % 100) < 3)
                set_redirect(($urandom % 8 == 0) ? 32'hFFFF_FFFD + ($urandom % 3) : $urandom % 256);
            #1;
            if (halted || halt || redirect) chk("rand_no_issue", im_oen, 1);
            chk("rand_wen", im_wen, 1);
            step();
        end
        halt     = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b1;
        redir_check(32'h55, 0);
        chk("liveness", n_deliv > 300, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
